// File: rtl/hs_channel_arbiter.sv
// Round-robin arbiter that serialises per-requester event counts onto one
// four-phase handshake channel. Optional watchdog: define HS_TIMEOUT_EN.
module hs_channel_arbiter #(
   parameter int N_REQ       = 4,
   parameter int ID_W        = 2,
   parameter int CNT_W       = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req_in,
   input  logic             out_rdy,
   output logic             out,
   output logic [ID_W-1:0]  out_id,
   output logic [N_REQ-1:0] tx_ing,
   output logic             busy,
   output logic [N_REQ-1:0] ovf,
   output logic             timeout_err
);

   typedef enum logic [1:0] {IDLE, TX_HIGH, TX_LOW} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_reg;
   logic [N_REQ-1:0] req_q_reg;
   logic             rdy_q_reg;
   logic [ID_W-1:0]  grant_reg;
   logic [ID_W-1:0]  last_grant_reg;
   logic [ID_W-1:0]  grant_next;
   logic             grant_found;
   logic             out_reg;
   logic [ID_W-1:0]  out_id_reg;

   logic [N_REQ-1:0] rise;
   logic [N_REQ-1:0] done;
   logic             rdy_rise;
   logic             rdy_fall;
   logic             advance;
   logic             abort;
   logic             complete;

   assign rise     = req_in & ~req_q_reg;
   assign rdy_rise = out_rdy & ~rdy_q_reg;
   assign rdy_fall = ~out_rdy & rdy_q_reg;
   assign advance  = ((state_reg == TX_HIGH) && rdy_rise) ||
                     ((state_reg == TX_LOW) && rdy_fall);
   assign complete = ((state_reg == TX_LOW) && rdy_fall) || abort;

`ifdef HS_TIMEOUT_EN
   localparam int PH_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

   logic [PH_W-1:0] phase_reg;
   logic            tout_reg;

   // Abort on the edge that would take the phase count to TIMEOUT_CYC.
   assign abort = (state_reg != IDLE) && !advance &&
                  (phase_reg == PH_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_reg <= '0;
         tout_reg  <= 1'b0;
      end else begin
         tout_reg <= abort;
         if ((state_reg == IDLE) || advance || abort)
            phase_reg <= '0;
         else
            phase_reg <= phase_reg + 1'b1;
      end
   end

   assign timeout_err = tout_reg;
`else
   logic unused_timeout;

   assign abort          = 1'b0;
   assign timeout_err    = 1'b0;
   assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
         logic [CNT_W-1:0] cnt_reg;
         logic             ovf_reg;

         assign done[gi]   = complete && (grant_reg == ID_W'(gi));
         assign tx_ing[gi] = (cnt_reg != '0);
         assign ovf[gi]    = ovf_reg;

         // A rise coinciding with completion cancels out; a full counter drops the event.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               cnt_reg <= '0;
               ovf_reg <= 1'b0;
            end else if (rise[gi] && !done[gi]) begin
               if (cnt_reg == CNT_MAX)
                  ovf_reg <= 1'b1;
               else
                  cnt_reg <= cnt_reg + 1'b1;
            end else if (done[gi] && !rise[gi]) begin
               cnt_reg <= cnt_reg - 1'b1;
            end
         end
      end
   endgenerate

   // First pending requester after the last one served, wrapping modulo N_REQ.
   always_comb begin
      int idx;
      idx         = 0;
      grant_next  = '0;
      grant_found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last_grant_reg) + k) % N_REQ;
         if (!grant_found && tx_ing[idx]) begin
            grant_next  = ID_W'(idx);
            grant_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         req_q_reg      <= '0;
         rdy_q_reg      <= 1'b0;
         grant_reg      <= '0;
         last_grant_reg <= ID_W'(N_REQ - 1);
         out_reg        <= 1'b0;
         out_id_reg     <= '0;
      end else begin
         req_q_reg <= req_in;
         rdy_q_reg <= out_rdy;
         unique case (state_reg)
            IDLE: begin
               if (grant_found) begin
                  grant_reg  <= grant_next;
                  out_id_reg <= grant_next;
                  out_reg    <= 1'b1;
                  state_reg  <= TX_HIGH;
               end
            end
            TX_HIGH: begin
               if (abort) begin
                  last_grant_reg <= grant_reg;
                  out_reg        <= 1'b0;
                  out_id_reg     <= '0;
                  state_reg      <= IDLE;
               end else if (rdy_rise) begin
                  out_reg   <= 1'b0;
                  state_reg <= TX_LOW;
               end
            end
            TX_LOW: begin
               if (rdy_fall || abort) begin
                  last_grant_reg <= grant_reg;
                  out_id_reg     <= '0;
                  state_reg      <= IDLE;
               end
            end
            default: begin
               out_reg    <= 1'b0;
               out_id_reg <= '0;
               state_reg  <= IDLE;
            end
         endcase
      end
   end

   assign out  = out_reg;
   assign out_id = out_id_reg;
   assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_hs_channel_arbiter.sv
// Scoreboard bench for hs_channel_arbiter (default build, watchdog disabled).
module tb_hs_channel_arbiter;

   localparam int N_REQ = 4;
   localparam int ID_W  = 2;
   localparam int CNT_W = 4;

   logic             clk     = 1'b0;
   logic             rst     = 1'b0;
   logic [N_REQ-1:0] req_in  = '0;
   logic             out_rdy = 1'b0;
   logic             out;
   logic [ID_W-1:0]  out_id;
   logic [N_REQ-1:0] tx_ing;
   logic             busy;
   logic [N_REQ-1:0] ovf;
   logic             timeout_err;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_q[$];

   hs_channel_arbiter #(
      .N_REQ      (N_REQ),
      .ID_W       (ID_W),
      .CNT_W      (CNT_W),
      .TIMEOUT_CYC(255)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_in     (req_in),
      .out_rdy    (out_rdy),
      .out        (out),
      .out_id     (out_id),
      .tx_ing     (tx_ing),
      .busy       (busy),
      .ovf        (ovf),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      req_in  = '0;
      out_rdy = 1'b0;
      rst     = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   // Wait (bounded) for out to rise, then compare out_id with the scoreboard head.
   task automatic wait_grant();
      int n;
      int exp_id;
      n = 0;
      while (out !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (out !== 1'b1) begin
         check("grant_wait", 32'(out), 32'd1);
         return;
      end
      if (exp_q.size() == 0) begin
         check("sb_nonempty", 32'(exp_q.size()), 32'd1);
         return;
      end
      exp_id = exp_q.pop_front();
      check("out_id", 32'(out_id), 32'(exp_id));
      check("timeout_err", 32'(timeout_err), 32'd0);
      $display("xfer: out_id=%0d expected=%0d tx_ing=%b", out_id, exp_id, tx_ing);
   endtask

   task automatic serve_one();
      logic [ID_W-1:0] id_held;
      wait_grant();
      id_held = out_id;
      out_rdy = 1'b1;
      tick();
      check("tx_low_out", 32'(out), 32'd0);
      check("tx_low_id", 32'(out_id), 32'(id_held));
      out_rdy = 1'b0;
      tick();
      check("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int mcnt;

      // Reset state
      tick();
      tick();
      check("rst_out", 32'(out), 32'd0);
      check("rst_out_id", 32'(out_id), 32'd0);
      check("rst_tx_ing", 32'(tx_ing), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_timeout", 32'(timeout_err), 32'd0);
      rst = 1'b1;
      tick();

      // Single event on requester 2, with latency check
      req_in = 4'b0100;
      exp_q.push_back(2);
      tick();
      check("single_txing", 32'(tx_ing), 32'b0100);
      check("single_out_t1", 32'(out), 32'd0);
      tick();
      check("single_out_t2", 32'(out), 32'd1);
      check("single_busy", 32'(busy), 32'd1);
      tick();
      req_in = '0;
      serve_one();
      check("single_txing_clr", 32'(tx_ing), 32'd0);
      check("single_id_idle", 32'(out_id), 32'd0);

      // Round robin from reset
      apply_reset();
      req_in = 4'b1111;
      for (int i = 0; i < N_REQ; i++) exp_q.push_back(i);
      tick();
      req_in = '0;
      for (int i = 0; i < N_REQ; i++) serve_one();
      check("rr_txing_clr", 32'(tx_ing), 32'd0);

      // Queueing and saturation on requester 1
      mcnt = 0;
      for (int p = 0; p < 16; p++) begin
         req_in = 4'b0010;
         tick();
         if (mcnt < (1 << CNT_W) - 1) begin
            mcnt++;
            exp_q.push_back(1);
         end
         req_in = '0;
         tick();
         if (p == 14) check("ovf_pre", 32'(ovf), 32'd0);
      end
      check("ovf_set", 32'(ovf), 32'b0010);
      for (int i = 0; i < mcnt; i++) serve_one();
      for (int i = 0; i < 5; i++) tick();
      check("ovf_no_extra", 32'(out), 32'd0);
      check("ovf_txing_clr", 32'(tx_ing), 32'd0);
      check("ovf_sticky", 32'(ovf), 32'b0010);

      // Reset mid-transfer with counts {3,1,0,2}
      req_in = 4'b1011; tick();
      req_in = 4'b0000; tick();
      req_in = 4'b1001; tick();
      req_in = 4'b0000; tick();
      req_in = 4'b0001; tick();
      req_in = 4'b0000; tick();
      check("pre_rst_out", 32'(out), 32'd1);
      check("pre_rst_txing", 32'(tx_ing), 32'b1011);
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_out", 32'(out), 32'd0);
      check("mid_rst_txing", 32'(tx_ing), 32'd0);
      check("mid_rst_ovf", 32'(ovf), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      tick();
      rst = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check("post_rst_out", 32'(out), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);

      // Rise on requester 1 coinciding with its own completion
      req_in = 4'b0010;
      exp_q.push_back(1);
      tick();
      req_in = '0;
      wait_grant();
      out_rdy = 1'b1;
      tick();
      check("simul_tx_low", 32'(out), 32'd0);
      req_in = 4'b0100;
      tick();
      out_rdy = 1'b0;
      req_in  = 4'b0110;
      tick();
      check("simul_txing", 32'(tx_ing), 32'b0110);
      check("simul_busy", 32'(busy), 32'd0);
      exp_q.push_back(2);
      exp_q.push_back(1);
      req_in = '0;
      serve_one();
      serve_one();
      for (int i = 0; i < 4; i++) tick();
      check("simul_txing_clr", 32'(tx_ing), 32'd0);
      check("simul_no_extra", 32'(out), 32'd0);

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
